prog_mem_pipe: RTL and testbench

Parametrised, loadable instruction memory that succeeds the 8-bit combinational ROM in the CPU fetch path. It adds a synchronous read with selectable latency and valid/ready handshakes on both request and response. A load port fills the memory from the bootloader or testbench. Out-of-range accesses are flagged, and a wrapping counter tracks completed fetches.

---
 rtl/prog_mem_pipe.sv | 136 +++++++++++++
 tb/tb_prog_mem_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_pipe.sv
// Loadable instruction memory for the fetch path. It has a synchronous read with one or two
// stages, valid/ready handshakes on request and response, range flags and a fetch counter.
module prog_mem_pipe #(
    parameter int unsigned       DATA_W  = 8,
    parameter int unsigned       ADDR_W  = 8,
    parameter int unsigned       DEPTH   = 256,
    parameter int unsigned       OUT_REG = 0,
    parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_err,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [15:0]       fetch_cnt
);

    // One extra bit so that DEPTH == 2**ADDR_W can be represented and compared.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              s0_valid_q, s0_valid_d;
    logic [DATA_W-1:0] s0_data_q,  s0_data_d;
    logic              s0_err_q,   s0_err_d;
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q,  s1_data_d;
    logic              s1_err_q,   s1_err_d;
    logic              ld_err_q,   ld_err_d;
    logic [15:0]       fetch_cnt_q, fetch_cnt_d;

    logic              ld_in_range;
    logic              req_in_range;
    logic              req_accept;
    logic              s1_take;
    logic [DATA_W-1:0] rd_word;

    assign ld_in_range  = {1'b0, ld_addr}  < DEPTH_L;
    assign req_in_range = {1'b0, req_addr} < DEPTH_L;

    always_comb begin
        s0_valid_d  = s0_valid_q;
        s0_data_d   = s0_data_q;
        s0_err_d    = s0_err_q;
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_err_d    = s1_err_q;
        s1_take     = 1'b0;
        req_ready   = 1'b0;
        req_accept  = 1'b0;
        rd_word     = req_in_range ? mem_q[req_addr] : NOP_VAL;

        if (OUT_REG != 0) begin
            s1_take    = s0_valid_q && (!s1_valid_q || rsp_ready);
            req_ready  = !ld_en && (!s0_valid_q || s1_take);
            req_accept = req_valid && req_ready;

            if (s1_take) begin
                s1_valid_d = 1'b1;
                s1_data_d  = s0_data_q;
                s1_err_d   = s0_err_q;
            end else if (rsp_ready) begin
                s1_valid_d = 1'b0;
            end

            if (req_accept) begin
                s0_valid_d = 1'b1;
                s0_data_d  = rd_word;
                s0_err_d   = !req_in_range;
            end else if (s1_take) begin
                s0_valid_d = 1'b0;
            end
        end else begin
            req_ready  = !ld_en && (!s1_valid_q || rsp_ready);
            req_accept = req_valid && req_ready;

            if (req_accept) begin
                s1_valid_d = 1'b1;
                s1_data_d  = rd_word;
                s1_err_d   = !req_in_range;
            end else if (rsp_ready) begin
                s1_valid_d = 1'b0;
            end
        end

        ld_err_d    = ld_en && !ld_in_range;
        fetch_cnt_d = fetch_cnt_q;
        if (s1_valid_q && rsp_ready) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
    end

    // Array contents survive reset so a reset does not force a reload.
    always_ff @(posedge clk) begin
        if (ld_en && ld_in_range) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q  <= 1'b0;
            s0_data_q   <= NOP_VAL;
            s0_err_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= NOP_VAL;
            s1_err_q    <= 1'b0;
            ld_err_q    <= 1'b0;
            fetch_cnt_q <= 16'd0;
        end else begin
            s0_valid_q  <= s0_valid_d;
            s0_data_q   <= s0_data_d;
            s0_err_q    <= s0_err_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_err_q    <= s1_err_d;
            ld_err_q    <= ld_err_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign rsp_valid = s1_valid_q;
    assign rsp_data  = s1_data_q;
    assign rsp_err   = s1_err_q;
    assign ld_err    = ld_err_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_prog_mem_pipe.sv
// Directed bench for prog_mem_pipe: dut_a is full depth with latency 1, and dut_b has
// DEPTH=200 with the output register enabled (latency 2).
`timescale 1ns/1ps
module tb_prog_mem_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_ld_en, a_ld_err, a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [7:0]  a_ld_addr, a_ld_data, a_req_addr, a_rsp_data;
    logic [15:0] a_fetch_cnt;
    logic        b_ld_en, b_ld_err, b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [7:0]  b_ld_addr, b_ld_data, b_req_addr, b_rsp_data;
    logic [15:0] b_fetch_cnt;

    int checks   = 0;
    int failures = 0;

    prog_mem_pipe #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .OUT_REG(0), .NOP_VAL(8'h00)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data), .ld_err(a_ld_err),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
        .rsp_err(a_rsp_err), .fetch_cnt(a_fetch_cnt)
    );

    prog_mem_pipe #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .OUT_REG(1), .NOP_VAL(8'h00)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data), .ld_err(b_ld_err),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .rsp_err(b_rsp_err), .fetch_cnt(b_fetch_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_a_rsp_valid got=%0h exp=0", a_rsp_valid); end
        checks++; if (a_rsp_data !== 8'h00) begin failures++; $display("FAIL reset_a_rsp_data got=%h exp=00", a_rsp_data); end
        checks++; if (a_rsp_err !== 1'b0) begin failures++; $display("FAIL reset_a_rsp_err got=%0h exp=0", a_rsp_err); end
        checks++; if (a_ld_err !== 1'b0) begin failures++; $display("FAIL reset_a_ld_err got=%0h exp=0", a_ld_err); end
        checks++; if (a_fetch_cnt !== 16'h0000) begin failures++; $display("FAIL reset_a_fetch_cnt got=%h exp=0000", a_fetch_cnt); end
        checks++; if (b_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_b_rsp_valid got=%0h exp=0", b_rsp_valid); end
        checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL reset_b_req_ready got=%0h exp=1", b_req_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_read;
        logic [7:0] la [3] = '{8'h00, 8'h01, 8'hFF};
        logic [7:0] da [3] = '{8'hA5, 8'h3C, 8'hE7};
        logic [7:0] lb [5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hC7};
        logic [7:0] db [5] = '{8'hA5, 8'h3C, 8'h11, 8'h22, 8'h5A};
        for (int i = 0; i < 5; i++) begin
            a_ld_en = (i < 3);
            if (i < 3) begin a_ld_addr = la[i]; a_ld_data = da[i]; end
            b_ld_en = 1'b1; b_ld_addr = lb[i]; b_ld_data = db[i];
            tick();
        end
        a_ld_en = 1'b0; b_ld_en = 1'b0;
        a_rsp_ready = 1'b1; a_req_valid = 1'b1; a_req_addr = 8'h00;
        #1;
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL lr_req_ready got=%0h exp=1", a_req_ready); end
        for (int j = 0; j < 4; j++) begin
            if (j < 3) begin a_req_valid = 1'b1; a_req_addr = la[j]; end
            else a_req_valid = 1'b0;
            tick();
            if (j < 3) begin
                checks++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== da[j] || a_rsp_err !== 1'b0) begin
                    failures++; $display("FAIL lr_rsp%0d got v=%0h d=%h e=%0h exp v=1 d=%h e=0", j, a_rsp_valid, a_rsp_data, a_rsp_err, da[j]);
                end
            end else begin
                checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL lr_idle got=%0h exp=0", a_rsp_valid); end
            end
        end
        checks++; if (a_fetch_cnt !== 16'd3) begin failures++; $display("FAIL lr_fetch_cnt got=%0d exp=3", a_fetch_cnt); end
    endtask

    task automatic test_latency;
        logic [7:0] exp_d [4] = '{8'hA5, 8'h3C, 8'h11, 8'h22};
        b_rsp_ready = 1'b1; b_req_valid = 1'b1; b_req_addr = 8'h01;
        #1;
        checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL lat_req_ready got=%0h exp=1", b_req_ready); end
        tick();
        b_req_valid = 1'b0;
        checks++; if (b_rsp_valid !== 1'b0) begin failures++; $display("FAIL lat_early_valid got=%0h exp=0", b_rsp_valid); end
        tick();
        checks++; if (b_rsp_valid !== 1'b1 || b_rsp_data !== 8'h3C || b_rsp_err !== 1'b0) begin
            failures++; $display("FAIL lat_rsp got v=%0h d=%h e=%0h exp v=1 d=3c e=0", b_rsp_valid, b_rsp_data, b_rsp_err);
        end
        tick();
        checks++; if (b_rsp_valid !== 1'b0) begin failures++; $display("FAIL lat_after got=%0h exp=0", b_rsp_valid); end
        for (int j = 0; j < 6; j++) begin
            if (j < 4) begin b_req_valid = 1'b1; b_req_addr = 8'(j); end
            else b_req_valid = 1'b0;
            #1;
            if (j < 4) begin
                checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL stream_ready%0d got=%0h exp=1", j, b_req_ready); end
            end
            tick();
            if (j >= 1 && j <= 4) begin
                checks++; if (b_rsp_valid !== 1'b1 || b_rsp_data !== exp_d[j-1]) begin
                    failures++; $display("FAIL stream_rsp%0d got v=%0h d=%h exp v=1 d=%h", j-1, b_rsp_valid, b_rsp_data, exp_d[j-1]);
                end
            end else if (j == 5) begin
                checks++; if (b_rsp_valid !== 1'b0) begin failures++; $display("FAIL stream_end got=%0h exp=0", b_rsp_valid); end
            end
        end
        checks++; if (b_fetch_cnt !== 16'd5) begin failures++; $display("FAIL stream_fetch_cnt got=%0d exp=5", b_fetch_cnt); end
    endtask

    task automatic test_backpressure;
        logic [7:0] drain [2] = '{8'h3C, 8'h11};
        b_rsp_ready = 1'b0; b_req_valid = 1'b1; b_req_addr = 8'h00;
        #1;
        checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready0 got=%0h exp=1", b_req_ready); end
        tick();
        b_req_addr = 8'h01;
        #1;
        checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%0h exp=1", b_req_ready); end
        tick();
        b_req_addr = 8'h02;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (b_req_ready !== 1'b0 || b_rsp_valid !== 1'b1 || b_rsp_data !== 8'hA5) begin
                failures++; $display("FAIL bp_stall%0d got rdy=%0h v=%0h d=%h exp rdy=0 v=1 d=a5", k, b_req_ready, b_rsp_valid, b_rsp_data);
            end
            tick();
        end
        b_rsp_ready = 1'b1;
        #1;
        checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0h exp=1", b_req_ready); end
        for (int k = 0; k < 2; k++) begin
            tick();
            b_req_valid = 1'b0;
            checks++; if (b_rsp_valid !== 1'b1 || b_rsp_data !== drain[k]) begin
                failures++; $display("FAIL bp_drain%0d got v=%0h d=%h exp v=1 d=%h", k, b_rsp_valid, b_rsp_data, drain[k]);
            end
        end
        tick();
        checks++; if (b_rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0h exp=0", b_rsp_valid); end
        checks++; if (b_fetch_cnt !== 16'd8) begin failures++; $display("FAIL bp_fetch_cnt got=%0d exp=8", b_fetch_cnt); end
    endtask

    task automatic test_range;
        logic [7:0] addr  [4] = '{8'hC7, 8'hC8, 8'hD0, 8'hC7};
        logic [7:0] exp_d [4] = '{8'h5A, 8'h00, 8'h00, 8'h5A};
        logic       exp_e [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        b_ld_en = 1'b1; b_ld_addr = 8'hD0; b_ld_data = 8'h99;
        tick();
        b_ld_en = 1'b0;
        checks++; if (b_ld_err !== 1'b1) begin failures++; $display("FAIL range_ld_err_pulse got=%0h exp=1", b_ld_err); end
        tick();
        checks++; if (b_ld_err !== 1'b0) begin failures++; $display("FAIL range_ld_err_clear got=%0h exp=0", b_ld_err); end
        b_rsp_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (j < 4) begin b_req_valid = 1'b1; b_req_addr = addr[j]; end
            else b_req_valid = 1'b0;
            tick();
            if (j >= 1 && j <= 4) begin
                checks++; if (b_rsp_valid !== 1'b1 || b_rsp_data !== exp_d[j-1] || b_rsp_err !== exp_e[j-1]) begin
                    failures++; $display("FAIL range_rsp_%h got v=%0h d=%h e=%0h exp v=1 d=%h e=%0h",
                                         addr[j-1], b_rsp_valid, b_rsp_data, b_rsp_err, exp_d[j-1], exp_e[j-1]);
                end
            end else if (j == 5) begin
                checks++; if (b_rsp_valid !== 1'b0) begin failures++; $display("FAIL range_end got=%0h exp=0", b_rsp_valid); end
            end
        end
    endtask

    task automatic test_collision;
        a_rsp_ready = 1'b1;
        a_ld_en = 1'b1; a_ld_addr = 8'h05; a_ld_data = 8'h77;
        a_req_valid = 1'b1; a_req_addr = 8'h05;
        #1;
        checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL coll_ready_ld got=%0h exp=0", a_req_ready); end
        tick();
        a_ld_en = 1'b0;
        #1;
        checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL coll_no_rsp got=%0h exp=0", a_rsp_valid); end
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL coll_ready_after got=%0h exp=1", a_req_ready); end
        tick();
        a_req_valid = 1'b0;
        checks++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 8'h77 || a_rsp_err !== 1'b0) begin
            failures++; $display("FAIL coll_rsp got v=%0h d=%h e=%0h exp v=1 d=77 e=0", a_rsp_valid, a_rsp_data, a_rsp_err);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        b_rsp_ready = 1'b1; b_req_valid = 1'b1; b_req_addr = 8'h00;
        a_rsp_ready = 1'b0; a_req_valid = 1'b1; a_req_addr = 8'h01;
        tick();
        b_req_addr = 8'h01; a_req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        b_req_valid = 1'b0;
        checks++; if (b_rsp_valid !== 1'b0 || b_rsp_data !== 8'h00 || b_fetch_cnt !== 16'd0) begin
            failures++; $display("FAIL rstmid_b got v=%0h d=%h cnt=%0d exp v=0 d=00 cnt=0", b_rsp_valid, b_rsp_data, b_fetch_cnt);
        end
        checks++; if (a_rsp_valid !== 1'b0 || a_rsp_data !== 8'h00 || a_fetch_cnt !== 16'd0) begin
            failures++; $display("FAIL rstmid_a got v=%0h d=%h cnt=%0d exp v=0 d=00 cnt=0", a_rsp_valid, a_rsp_data, a_fetch_cnt);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (b_rsp_valid !== 1'b0 || a_rsp_valid !== 1'b0) begin
                failures++; $display("FAIL rstmid_stale%0d got a=%0h b=%0h exp 0", k, a_rsp_valid, b_rsp_valid);
            end
        end
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        a_req_valid = 1'b1; a_req_addr = 8'h01;
        b_req_valid = 1'b1; b_req_addr = 8'h01;
        tick();
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        checks++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 8'h3C) begin
            failures++; $display("FAIL rstmid_a_retain got v=%0h d=%h exp v=1 d=3c", a_rsp_valid, a_rsp_data);
        end
        tick();
        checks++; if (b_rsp_valid !== 1'b1 || b_rsp_data !== 8'h3C) begin
            failures++; $display("FAIL rstmid_b_retain got v=%0h d=%h exp v=1 d=3c", b_rsp_valid, b_rsp_data);
        end
        tick();
    endtask

    task automatic test_wrap;
        int n = 0;
        checks++; if (a_fetch_cnt !== 16'd1) begin failures++; $display("FAIL wrap_start got=%0d exp=1", a_fetch_cnt); end
        a_rsp_ready = 1'b1; a_req_valid = 1'b1; a_req_addr = 8'h00;
        while (a_fetch_cnt !== 16'hFFFF && n < 70000) begin
            tick();
            n++;
        end
        checks++; if (a_fetch_cnt !== 16'hFFFF || n != 65535) begin
            failures++; $display("FAIL wrap_ffff got cnt=%h cycles=%0d exp cnt=ffff cycles=65535", a_fetch_cnt, n);
        end
        tick();
        a_req_valid = 1'b0;
        checks++; if (a_fetch_cnt !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", a_fetch_cnt); end
        tick();
    endtask

    initial begin
        a_ld_en = 1'b0; a_ld_addr = '0; a_ld_data = '0; a_req_valid = 1'b0; a_req_addr = '0; a_rsp_ready = 1'b0;
        b_ld_en = 1'b0; b_ld_addr = '0; b_ld_data = '0; b_req_valid = 1'b0; b_req_addr = '0; b_rsp_ready = 1'b0;
        test_reset();
        test_load_read();
        test_latency();
        test_backpressure();
        test_range();
        test_collision();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
